// File: rtl/multi_lane_alu_pkg.sv
// Shared op encoding for the multi-lane ALU and its lane units.
package multi_lane_alu_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SAT  = 2'b10,
    OP_PASS = 2'b11
  } lane_op_e;

endpackage

// File: rtl/alu_lane.sv
// Single-lane combinational op unit: ADD/SUB wrap, SAT clamps (MULTI_LANE_ALU_SAT_EN) or wraps, PASS forwards a.
// Latency 0; no flow control, the parent pipeline owns backpressure.
module alu_lane
  import multi_lane_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_W-1:0]       op,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH-1:0] sat_y;

`ifdef MULTI_LANE_ALU_SAT_EN
  logic [DATA_WIDTH:0] sum_ext;

  always_comb begin
    sum_ext = {1'b0, a} + {1'b0, b};
    sat_y   = sum_ext[DATA_WIDTH] ? '1 : sum_ext[DATA_WIDTH-1:0];
  end
`else
  always_comb begin
    sat_y = a + b;
  end
`endif

  always_comb begin
    y = a + b;
    case (lane_op_e'(op))
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SAT:  y = sat_y;
      OP_PASS: y = a;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/multi_lane_alu.sv
// N-lane ALU, two register stages, plus running accumulator of the cross-lane sum (SAT via MULTI_LANE_ALU_SAT_EN).
// Latency 2 cycles; both stages advance together only when the output slot is empty or being consumed.
module multi_lane_alu
  import multi_lane_alu_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] operand,
  input  logic [NUM_LANES*OP_W-1:0]       op,
  input  logic                            acc_clear,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] result,
  output logic [ACC_WIDTH-1:0]            acc_out,
  output logic                            acc_ovf
);

  localparam int VEC_W = NUM_LANES * DATA_WIDTH;

  // The reduction is only overflow-free if the accumulator can hold a full lane sum.
  if (ACC_WIDTH < DATA_WIDTH + $clog2(NUM_LANES)) begin : g_acc_width_chk
    $error("multi_lane_alu: ACC_WIDTH too narrow for the cross-lane sum");
  end

  logic [VEC_W-1:0]     lane_res;
  logic                 s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [VEC_W-1:0]     s1_dat_q, s1_dat_d, s2_dat_q, s2_dat_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, red;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 ovf_q, ovf_d;
  logic                 en, acc_upd;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    alu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .a  (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .b  (operand[g*DATA_WIDTH +: DATA_WIDTH]),
      .op (op[g*OP_W +: OP_W]),
      .y  (lane_res[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign en       = !s2_vld_q || out_ready;
  assign acc_upd  = en && s1_vld_q;
  assign in_ready = en;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_dat_d = s1_dat_q;
    s2_vld_d = s2_vld_q;
    s2_dat_d = s2_dat_q;
    if (en) begin
      s1_vld_d = in_valid;
      s1_dat_d = lane_res;
      s2_vld_d = s1_vld_q;
      s2_dat_d = s1_dat_q;
    end
  end

  always_comb begin
    red = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      red = red + ACC_WIDTH'(s1_dat_q[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Clear wins over the old value but not over a coincident beat: clear-then-add.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, red};
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (acc_clear) begin
      acc_d = acc_upd ? red : '0;
      ovf_d = 1'b0;
    end else if (acc_upd) begin
      acc_d = acc_sum[ACC_WIDTH-1:0];
      ovf_d = ovf_q | acc_sum[ACC_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      s2_vld_q <= s2_vld_d;
      s2_dat_q <= s2_dat_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign result    = s2_dat_q;
  assign acc_out   = acc_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_multi_lane_alu.sv
// Directed self-checking bench for multi_lane_alu (4 lanes x 8 bits, 16-bit accumulator).
module tb_multi_lane_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [31:0] operand;
  logic [7:0]  op;
  logic        acc_clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [15:0] acc_out;
  logic        acc_ovf;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] OPS_PASS = 8'b11_11_11_11;

  multi_lane_alu #(.NUM_LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .operand   (operand),
    .op        (op),
    .acc_clear (acc_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .acc_out   (acc_out),
    .acc_ovf   (acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; data_in = '0; operand = '0; op = '0;
    acc_clear = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_errors++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (acc_out !== 16'd0) begin n_errors++; $display("FAIL reset_acc: got %0d want 0", acc_out); end
    n_checks++; if (acc_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %0b want 0", acc_ovf); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_mixed_ops(output logic [15:0] acc_exp);
    logic [31:0] res_exp;
`ifdef MULTI_LANE_ALU_SAT_EN
    res_exp = {8'd5, 8'd255, 8'd246, 8'd13};
    acc_exp = 16'd519;
`else
    res_exp = {8'd5, 8'd44, 8'd246, 8'd13};
    acc_exp = 16'd308;
`endif
    data_in  = {8'd5, 8'd200, 8'd20, 8'd10};
    operand  = {8'd5, 8'd100, 8'd30, 8'd3};
    op       = 8'b11_10_01_00;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mixed_early_valid: got %0b want 0", out_valid); end
    tick;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mixed_valid: got %0b want 1", out_valid); end
    n_checks++; if (result !== res_exp) begin n_errors++; $display("FAIL mixed_result: got %h want %h", result, res_exp); end
    n_checks++; if (acc_out !== acc_exp) begin n_errors++; $display("FAIL mixed_acc: got %0d want %0d", acc_out, acc_exp); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mixed_bubble_valid: got %0b want 0", out_valid); end
    n_checks++; if (acc_out !== acc_exp) begin n_errors++; $display("FAIL mixed_bubble_acc: got %0d want %0d", acc_out, acc_exp); end
  endtask

  task automatic test_backpressure(input logic [15:0] acc_base);
    logic [31:0] bp_dat [3];
    logic [15:0] bp_cum [3];
    int   n_acc, n_dlv;
    logic fire;
    bp_dat[0] = 32'd1; bp_dat[1] = 32'd2; bp_dat[2] = 32'd4;
    bp_cum[0] = acc_base + 16'd1; bp_cum[1] = acc_base + 16'd3; bp_cum[2] = acc_base + 16'd7;
    op = OPS_PASS; operand = '0;
    n_acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (n_acc < 3);
      data_in  = bp_dat[(n_acc < 3) ? n_acc : 2];
      fire = in_valid && in_ready;
      tick;
      if (fire) n_acc++;
    end
    n_checks++; if (n_acc !== 2) begin n_errors++; $display("FAIL bp_accepted: got %0d want 2", n_acc); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    n_checks++; if (result !== bp_dat[0]) begin n_errors++; $display("FAIL bp_frozen_result: got %h want %h", result, bp_dat[0]); end
    n_checks++; if (acc_out !== bp_cum[0]) begin n_errors++; $display("FAIL bp_frozen_acc: got %0d want %0d", acc_out, bp_cum[0]); end
    out_ready = 1'b1;
    n_dlv = 0;
    for (int c = 0; c < 10 && n_dlv < 3; c++) begin
      in_valid = (n_acc < 3);
      data_in  = bp_dat[(n_acc < 3) ? n_acc : 2];
      fire = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_checks++; if (result !== bp_dat[n_dlv]) begin n_errors++; $display("FAIL bp_order_result%0d: got %h want %h", n_dlv, result, bp_dat[n_dlv]); end
        n_checks++; if (acc_out !== bp_cum[n_dlv]) begin n_errors++; $display("FAIL bp_order_acc%0d: got %0d want %0d", n_dlv, acc_out, bp_cum[n_dlv]); end
        n_dlv++;
      end
      tick;
      if (fire) n_acc++;
    end
    in_valid = 1'b0;
    n_checks++; if (n_dlv !== 3) begin n_errors++; $display("FAIL bp_delivered: got %0d want 3", n_dlv); end
    tick; tick;
  endtask

  task automatic test_clear_idle;
    acc_clear = 1'b1;
    tick;
    acc_clear = 1'b0;
    n_checks++; if (acc_out !== 16'd0) begin n_errors++; $display("FAIL clear_idle_acc: got %0d want 0", acc_out); end
    n_checks++; if (acc_ovf !== 1'b0) begin n_errors++; $display("FAIL clear_idle_ovf: got %0b want 0", acc_ovf); end
  endtask

  task automatic test_overflow;
    op = OPS_PASS; operand = '0; data_in = {4{8'd255}}; out_ready = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      in_valid = 1'b1;
      tick;
    end
    n_checks++; if (acc_out !== 16'd65280) begin n_errors++; $display("FAIL ovf_acc64: got %0d want 65280", acc_out); end
    n_checks++; if (acc_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_flag64: got %0b want 0", acc_ovf); end
    in_valid = 1'b0;
    tick;
    n_checks++; if (acc_out !== 16'd764) begin n_errors++; $display("FAIL ovf_acc65: got %0d want 764", acc_out); end
    n_checks++; if (acc_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_flag65: got %0b want 1", acc_ovf); end
    in_valid = 1'b1;
    tick; tick;
    in_valid = 1'b0;
    tick; tick;
    n_checks++; if (acc_out !== 16'd2804) begin n_errors++; $display("FAIL ovf_acc67: got %0d want 2804", acc_out); end
    n_checks++; if (acc_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %0b want 1", acc_ovf); end
  endtask

  task automatic test_clear_with_beat;
    op = OPS_PASS; data_in = {4{8'd10}};
    in_valid = 1'b1;
    tick;
    in_valid  = 1'b0;
    acc_clear = 1'b1;
    tick;
    acc_clear = 1'b0;
    n_checks++; if (acc_out !== 16'd40) begin n_errors++; $display("FAIL clear_beat_acc: got %0d want 40", acc_out); end
    n_checks++; if (acc_ovf !== 1'b0) begin n_errors++; $display("FAIL clear_beat_ovf: got %0b want 0", acc_ovf); end
    tick;
    acc_clear = 1'b1;
    tick;
    acc_clear = 1'b0;
    n_checks++; if (acc_out !== 16'd0) begin n_errors++; $display("FAIL clear_after_acc: got %0d want 0", acc_out); end
  endtask

  task automatic test_reset_mid_stream;
    bit seen;
    op = OPS_PASS; data_in = {4{8'd7}};
    in_valid = 1'b1;
    tick; tick;
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre_valid: got %0b want 1", out_valid); end
    rst = 1'b1;
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
    n_checks++; if (acc_out !== 16'd0) begin n_errors++; $display("FAIL rstmid_acc: got %0d want 0", acc_out); end
    rst = 1'b0;
    data_in  = 32'd3;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL rstmid_timeout: got no out_valid want one within 6 cycles"); end
    n_checks++; if (result !== 32'd3) begin n_errors++; $display("FAIL rstmid_result: got %h want 00000003", result); end
    n_checks++; if (acc_out !== 16'd3) begin n_errors++; $display("FAIL rstmid_post_acc: got %0d want 3", acc_out); end
  endtask

  initial begin
    logic [15:0] acc_mixed;
    test_reset;
    test_mixed_ops(acc_mixed);
    test_backpressure(acc_mixed);
    test_clear_idle;
    test_overflow;
    test_clear_with_beat;
    test_reset_mid_stream;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
